// File: rtl/vga_timing_mux.sv
// VGA timing generator plus frame-synchronous RGB source mux, with sync/DE delayed to match source latency.
// Optional build macro VGA_TIMING_MUX_SCANLINE_EN halves RGB on odd output lines.
module vga_timing_mux #(
    parameter int H_FRONT     = 2,
    parameter int H_SYNC      = 3,
    parameter int H_BACK      = 1,
    parameter int H_VISIBLE   = 8,
    parameter int V_FRONT     = 1,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 1,
    parameter int V_VISIBLE   = 4,
    parameter bit HS_POL      = 1'b0,
    parameter bit VS_POL      = 1'b0,
    parameter int NUM_SRC     = 3,
    parameter int SRC_LATENCY = 1,
    parameter int CNT_W       = 11
) (
    input  logic                   CLK_PIXEL,
    input  logic                   RESET_N,
    input  logic [2:0]             sel,
    input  logic [24*NUM_SRC-1:0]  src_rgb,
    output logic [CNT_W-1:0]       horizontal_counter,
    output logic [CNT_W-1:0]       vertical_counter,
    output logic [CNT_W-1:0]       pix_x,
    output logic [CNT_W-1:0]       pix_y,
    output logic                   frame_start,
    output logic [2:0]             active_sel,
    output logic [7:0]             VGA_R,
    output logic [7:0]             VGA_G,
    output logic [7:0]             VGA_B,
    output logic                   VGA_HS,
    output logic                   VGA_VS,
    output logic                   VGA_DE
);

    localparam int H_OFF   = H_FRONT + H_SYNC + H_BACK;
    localparam int H_TOTAL = H_OFF + H_VISIBLE;
    localparam int V_OFF   = V_FRONT + V_SYNC + V_BACK;
    localparam int V_TOTAL = V_OFF + V_VISIBLE;
    localparam int PIPE    = SRC_LATENCY + 1;

    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_OFF_C = CNT_W'(H_OFF);
    localparam logic [CNT_W-1:0] V_OFF_C = CNT_W'(V_OFF);
    localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_FRONT);
    localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_FRONT);
    localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_FRONT + V_SYNC);
    localparam logic [3:0]       NSRC_C  = 4'(NUM_SRC);

    generate
        if (H_TOTAL >= 2**CNT_W || V_TOTAL >= 2**CNT_W) begin : g_err_cnt_w
            $error("vga_timing_mux: H_TOTAL/V_TOTAL do not fit in CNT_W bits");
        end
        if (H_OFF < PIPE) begin : g_err_pipe
            $error("vga_timing_mux: horizontal blanking shorter than output pipeline");
        end
        if (NUM_SRC < 1 || NUM_SRC > 8) begin : g_err_nsrc
            $error("vga_timing_mux: NUM_SRC must be 1..8");
        end
        if (SRC_LATENCY < 0 || SRC_LATENCY > 4) begin : g_err_lat
            $error("vga_timing_mux: SRC_LATENCY must be 0..4");
        end
    endgenerate

`ifdef VGA_TIMING_MUX_SCANLINE_EN
    localparam int TAG_W = 4;
`else
    localparam int TAG_W = 3;
`endif

    logic              run_q;
    logic [CNT_W-1:0]  h_q, h_d, v_q, v_d;
    logic [CNT_W-1:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic              frame_start_q, frame_start_d;
    logic [2:0]        active_sel_q, active_sel_d;
    logic              vis_d;
    logic              hs0, vs0, de0;
    logic [PIPE-1:0]   hs_q, vs_q, de_q;
    logic [TAG_W-1:0]  tag0, tag_dly;
    logic [23:0]       src_sel, rgb_d, rgb_q;
    logic [23:0]       src_arr [NUM_SRC];

    // Counters hold at (0,0) for the first cycle after reset so that cycle carries frame_start.
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (run_q) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
        vis_d         = (h_d >= H_OFF_C) && (v_d >= V_OFF_C);
        pix_x_d       = vis_d ? h_d - H_OFF_C : '0;
        pix_y_d       = vis_d ? v_d - V_OFF_C : '0;
        frame_start_d = (h_d == '0) && (v_d == '0);
        active_sel_d  = active_sel_q;
        if (frame_start_q && ({1'b0, sel} < NSRC_C)) begin
            active_sel_d = sel;
        end
    end

    always_ff @(posedge CLK_PIXEL) begin
        if (!RESET_N) begin
            run_q         <= 1'b0;
            h_q           <= '0;
            v_q           <= '0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            frame_start_q <= 1'b0;
            active_sel_q  <= '0;
        end else begin
            run_q         <= 1'b1;
            h_q           <= h_d;
            v_q           <= v_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            frame_start_q <= frame_start_d;
            active_sel_q  <= active_sel_d;
        end
    end

    assign hs0 = (h_q >= HS_BEG) && (h_q < HS_END);
    assign vs0 = (v_q >= VS_BEG) && (v_q < VS_END);
    assign de0 = (h_q >= H_OFF_C) && (v_q >= V_OFF_C);

    // Sync/DE carried as "active" flags; polarity applied only at the pins.
    always_ff @(posedge CLK_PIXEL) begin
        if (!RESET_N) begin
            hs_q <= '0;
            vs_q <= '0;
            de_q <= '0;
        end else begin
            hs_q[0] <= hs0;
            vs_q[0] <= vs0;
            de_q[0] <= de0;
            for (int i = 1; i < PIPE; i++) begin
                hs_q[i] <= hs_q[i-1];
                vs_q[i] <= vs_q[i-1];
                de_q[i] <= de_q[i-1];
            end
        end
    end

    // The select (and line parity) follow the pixel tag through the source latency, so a
    // switch applied at (0,0) only affects pixels whose counter value is in the new frame.
`ifdef VGA_TIMING_MUX_SCANLINE_EN
    assign tag0 = {v_q[0], active_sel_q};
`else
    assign tag0 = active_sel_q;
`endif

    generate
        if (SRC_LATENCY == 0) begin : g_no_dly
            assign tag_dly = tag0;
        end else begin : g_dly
            logic [TAG_W-1:0] tag_q [SRC_LATENCY];
            always_ff @(posedge CLK_PIXEL) begin
                if (!RESET_N) begin
                    for (int i = 0; i < SRC_LATENCY; i++) tag_q[i] <= '0;
                end else begin
                    tag_q[0] <= tag0;
                    for (int i = 1; i < SRC_LATENCY; i++) tag_q[i] <= tag_q[i-1];
                end
            end
            assign tag_dly = tag_q[SRC_LATENCY-1];
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign src_arr[gi] = src_rgb[24*gi +: 24];
        end
    endgenerate

    always_comb begin
        src_sel = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (tag_dly[2:0] == 3'(k)) src_sel = src_arr[k];
        end
        rgb_d = src_sel;
`ifdef VGA_TIMING_MUX_SCANLINE_EN
        if (tag_dly[3]) begin
            rgb_d = {1'b0, src_sel[23:17], 1'b0, src_sel[15:9], 1'b0, src_sel[7:1]};
        end
`endif
    end

    always_ff @(posedge CLK_PIXEL) begin
        if (!RESET_N) rgb_q <= '0;
        else          rgb_q <= rgb_d;
    end

    assign horizontal_counter = h_q;
    assign vertical_counter   = v_q;
    assign pix_x              = pix_x_q;
    assign pix_y              = pix_y_q;
    assign frame_start        = frame_start_q;
    assign active_sel         = active_sel_q;
    assign VGA_DE             = de_q[PIPE-1];
    assign VGA_HS             = hs_q[PIPE-1] ? HS_POL : ~HS_POL;
    assign VGA_VS             = vs_q[PIPE-1] ? VS_POL : ~VS_POL;
    assign VGA_R              = VGA_DE ? rgb_q[23:16] : 8'h00;
    assign VGA_G              = VGA_DE ? rgb_q[15:8]  : 8'h00;
    assign VGA_B              = VGA_DE ? rgb_q[7:0]   : 8'h00;

endmodule

// File: tb/tb_vga_timing_mux.sv
// Bench for vga_timing_mux: two instances (latency 1 with constant sources, latency 3 with pixel-tagged sources).
module tb_vga_timing_mux;
    localparam int HT = 14, VT = 8, FT = HT*VT, HOFF = 6, VOFF = 4;

`ifdef VGA_TIMING_MUX_SCANLINE_EN
    localparam logic [23:0] SRC0 = 24'h808080;
`else
    localparam logic [23:0] SRC0 = 24'h112233;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  sel;
    logic [71:0] src_a, src_b;

    logic [10:0] a_h, a_v, a_px, a_py, b_h, b_v, b_px, b_py;
    logic        a_fs, b_fs, a_hs, a_vs, a_de, b_hs, b_vs, b_de;
    logic [2:0]  a_as, b_as;
    logic [7:0]  a_r, a_g, a_b, b_r, b_g, b_b;

    always #5 clk = ~clk;

    assign src_a = {24'hAABBCC, 24'h445566, SRC0};

    vga_timing_mux dut_a (
        .CLK_PIXEL(clk), .RESET_N(rst_n), .sel(sel), .src_rgb(src_a),
        .horizontal_counter(a_h), .vertical_counter(a_v), .pix_x(a_px), .pix_y(a_py),
        .frame_start(a_fs), .active_sel(a_as), .VGA_R(a_r), .VGA_G(a_g), .VGA_B(a_b),
        .VGA_HS(a_hs), .VGA_VS(a_vs), .VGA_DE(a_de));

    vga_timing_mux #(.SRC_LATENCY(3)) dut_b (
        .CLK_PIXEL(clk), .RESET_N(rst_n), .sel(sel), .src_rgb(src_b),
        .horizontal_counter(b_h), .vertical_counter(b_v), .pix_x(b_px), .pix_y(b_py),
        .frame_start(b_fs), .active_sel(b_as), .VGA_R(b_r), .VGA_G(b_g), .VGA_B(b_b),
        .VGA_HS(b_hs), .VGA_VS(b_vs), .VGA_DE(b_de));

    int tests = 0, fails = 0;
    int n = -1, epoch = 0;
    bit rst_prev = 1'b0;
    int app [64];
    int de_c = 0, hs_c = 0, vs_c = 0;
    int fs_pos [4];
    int fs_n = 0;
    int hh [4], vv [4];

    function automatic logic [23:0] tagv(int k, int h, int v);
        return {8'(16*(k+1)), 8'(h), 8'(v)};
    endfunction

    function automatic logic [23:0] const_src(int k);
        case (k)
            0:       return SRC0;
            1:       return 24'h445566;
            default: return 24'hAABBCC;
        endcase
    endfunction

    function automatic logic [23:0] dim(logic [23:0] c, int v);
`ifdef VGA_TIMING_MUX_SCANLINE_EN
        if (v % 2 == 1) return {c[23:16] >> 1, c[15:8] >> 1, c[7:0] >> 1};
`endif
        return c;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s n=%0d epoch=%0d got=%0h expected=%0h", nm, n, epoch, act, exp);
        end
    endtask

    // Source emulation for dut_b: pixel data for counter value t appears 3 cycles later.
    always @(posedge clk) begin
        #1;
        for (int i = 3; i > 0; i--) begin
            hh[i] = hh[i-1];
            vv[i] = vv[i-1];
        end
        hh[0] = int'(b_h);
        vv[0] = int'(b_v);
        src_b = {tagv(2, hh[3], vv[3]), tagv(1, hh[3], vv[3]), tagv(0, hh[3], vv[3])};
    end

    // Expected pins for an instance with output lag P, from frame position of the lagged pixel.
    task automatic exp_vga(input int P, input bit is_b, output logic ehs, output logic evs,
                           output logic ede, output logic [23:0] ergb);
        int p, fp, tp, hp, vp;
        ehs = 1'b1; evs = 1'b1; ede = 1'b0; ergb = '0;
        if (n >= P) begin
            p = n - P; fp = p / FT; tp = p % FT; hp = tp % HT; vp = tp / HT;
            ehs = !(hp >= 2 && hp < 5);
            evs = !(vp >= 1 && vp < 3);
            ede = (hp >= HOFF) && (vp >= VOFF);
            if (ede) ergb = dim(is_b ? tagv(app[fp], hp, vp) : const_src(app[fp]), vp);
        end
    endtask

    task automatic check_cycle();
        int f, t, h, v, eas, epx, epy;
        logic ehs, evs, ede;
        logic [23:0] ergb;
        if (!rst_prev) begin
            if (n >= 0) epoch++;
            n = -1; de_c = 0; hs_c = 0; vs_c = 0;
            chk("rst_h", 32'(a_h), 0);          chk("rst_v", 32'(a_v), 0);
            chk("rst_px", 32'(a_px), 0);        chk("rst_py", 32'(a_py), 0);
            chk("rst_fs", 32'(a_fs), 0);        chk("rst_as", 32'(a_as), 0);
            chk("rst_a_pins", 32'({a_hs, a_vs, a_de}), 32'b110);
            chk("rst_a_rgb", 32'({a_r, a_g, a_b}), 0);
            chk("rst_b_pins", 32'({b_hs, b_vs, b_de}), 32'b110);
            chk("rst_b_rgb", 32'({b_r, b_g, b_b}), 0);
            chk("rst_b_as", 32'(b_as), 0);
        end else begin
            n++;
            f = n / FT; t = n % FT; h = t % HT; v = t / HT;
            if (t == 0) begin
                app[f] = (sel < 3) ? int'(sel) : ((f == 0) ? 0 : app[f-1]);
                $display("[TB] epoch %0d frame %0d at n=%0d: sel=%0d -> applied %0d", epoch, f, n, sel, app[f]);
            end
            eas = (t == 0) ? ((f == 0) ? 0 : app[f-1]) : app[f];
            epx = (h >= HOFF && v >= VOFF) ? h - HOFF : 0;
            epy = (h >= HOFF && v >= VOFF) ? v - VOFF : 0;
            chk("a_h", 32'(a_h), h);   chk("a_v", 32'(a_v), v);
            chk("a_px", 32'(a_px), epx); chk("a_py", 32'(a_py), epy);
            chk("a_fs", 32'(a_fs), (t == 0) ? 1 : 0);
            chk("a_as", 32'(a_as), eas);
            chk("b_h", 32'(b_h), h);   chk("b_v", 32'(b_v), v);
            chk("b_as", 32'(b_as), eas);
            exp_vga(2, 1'b0, ehs, evs, ede, ergb);
            chk("a_pins", 32'({a_hs, a_vs, a_de}), 32'({ehs, evs, ede}));
            chk("a_rgb", 32'({a_r, a_g, a_b}), 32'(ergb));
            exp_vga(4, 1'b1, ehs, evs, ede, ergb);
            chk("b_pins", 32'({b_hs, b_vs, b_de}), 32'({ehs, evs, ede}));
            chk("b_rgb", 32'({b_r, b_g, b_b}), 32'(ergb));

            // Per-frame counts of dut_a output activity (14x8 default timing).
            if (n >= 2) begin
                if (a_de)  de_c++;
                if (!a_hs) hs_c++;
                if (!a_vs) vs_c++;
                if ((n - 2) % FT == FT - 1) begin
                    chk("frame_de_cycles", de_c, 32);
                    chk("frame_hs_low", hs_c, 24);
                    chk("frame_vs_low", vs_c, 28);
                    de_c = 0; hs_c = 0; vs_c = 0;
                end
            end
            if (epoch == 0 && a_fs === 1'b1 && fs_n < 4) begin
                fs_pos[fs_n] = n;
                fs_n++;
            end
            if (epoch == 0) begin
                if (n == 64)  chk("lit_a_rgb_first", 32'({a_r, a_g, a_b}), 32'(SRC0));
                if (n == 225) chk("lit_as_2", 32'(a_as), 2);
                if (n == 288) chk("lit_a_rgb_src2", 32'({a_r, a_g, a_b}), 32'h00AABBCC);
                if (n == 400) chk("lit_a_rgb_sel5_held", 32'({a_r, a_g, a_b}), 32'h00AABBCC);
                if (n == 512) chk("lit_a_rgb_src1", 32'({a_r, a_g, a_b}), 32'h00445566);
                if (n == 5)   chk("lit_b_hs_before", 32'(b_hs), 1);
                if (n == 6)   chk("lit_b_hs_start", 32'(b_hs), 0);
                if (n == 66)  chk("lit_b_rgb_tag", 32'({b_r, b_g, b_b}), 32'h00100604);
`ifdef VGA_TIMING_MUX_SCANLINE_EN
                if (n == 78)  chk("lit_scanline_odd", 32'({a_r, a_g, a_b}), 32'h00404040);
`endif
                if (n == 230) begin
                    chk("lit_fs_count", fs_n, 3);
                    chk("lit_fs0", fs_pos[0], 0);
                    chk("lit_fs1", fs_pos[1], 112);
                    chk("lit_fs2", fs_pos[2], 224);
                end
            end
        end
        rst_prev = rst_n;
    endtask

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            check_cycle();
        end
    end

    int drv_cyc;
    task automatic at_cycle(input int k);
        repeat (k - drv_cyc) @(posedge clk);
        #1;
        drv_cyc = k;
    endtask

    initial begin
        rst_n = 1'b0;
        sel   = 3'd0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
        drv_cyc = -1;
        at_cycle(187); sel = 3'd2;     // mid-frame (h=5,v=5) of frame 1
        at_cycle(300); sel = 3'd5;     // out of range at the frame-3 boundary
        at_cycle(350); sel = 3'd1;
        at_cycle(541); rst_n = 1'b0;   // (h=9,v=6) of frame 4
        at_cycle(542); rst_n = 1'b1;
        drv_cyc = -1;
        at_cycle(300);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/vga_timing_mux.md
Name: vga_timing_mux

Overview:
- Parametrised successor to the fixed in-line VGA timing logic in the emu top level.
- Generates horizontal/vertical counters, HS/VS/DE and visible-area coordinates from parameterised timings.
- Selects one of NUM_SRC RGB sources (CRT, teletype, console, …) and delays sync/DE to align with source pipeline latency.
- Source selection switches glitch-free, only at frame boundaries. Sits between the video output modules and the VGA pins, on CLK_PIXEL.

Parameters:
- H_FRONT, 2 — horizontal front-porch cycles; counter starts here.
- H_SYNC, 3 — horizontal sync pulse cycles.
- H_BACK, 1 — horizontal back-porch cycles.
- H_VISIBLE, 8 — visible pixels per line.
- V_FRONT, 1 — vertical front-porch lines.
- V_SYNC, 2 — vertical sync lines.
- V_BACK, 1 — vertical back-porch lines.
- V_VISIBLE, 4 — visible lines.
- HS_POL, 0 — active level of VGA_HS.
- VS_POL, 0 — active level of VGA_VS.
- NUM_SRC, 3 — number of RGB sources, 1..8.
- SRC_LATENCY, 1 — cycles from counter value to source RGB valid, 0..4.
- CNT_W, 11 — counter width.

Ports:
- CLK_PIXEL  in  1  pixel clock.
- RESET_N  in  1  synchronous, active-low reset.
- sel  in  3  requested source index.
- src_rgb  in  24*NUM_SRC  packed sources; source k occupies bits [24k+23:24k], R high byte.
- horizontal_counter  out  CNT_W  raw horizontal position, to sources.
- vertical_counter  out  CNT_W  raw vertical position, to sources.
- pix_x  out  CNT_W  visible-area x, i.e. horizontal_counter − H_OFF; 0 outside visible.
- pix_y  out  CNT_W  visible-area y, i.e. vertical_counter − V_OFF; 0 outside visible.
- frame_start  out  1  one-cycle pulse when counters are (0,0).
- active_sel  out  3  currently applied source.
- VGA_R, VGA_G, VGA_B  out  8 each  output colour.
- VGA_HS  out  1  horizontal sync.
- VGA_VS  out  1  vertical sync.
- VGA_DE  out  1  data enable.

Behaviour:
- Clock and reset: one clock, CLK_PIXEL. Reset is synchronous and active-low on RESET_N.
- Derived values:
  - H_OFF = H_FRONT+H_SYNC+H_BACK; H_TOTAL = H_OFF+H_VISIBLE.
  - V_OFF = V_FRONT+V_SYNC+V_BACK; V_TOTAL = V_OFF+V_VISIBLE.
  - PIPE = SRC_LATENCY+1.
  - Elaboration error if H_TOTAL or V_TOTAL ≥ 2^CNT_W, if H_OFF < PIPE, or if NUM_SRC is out of range.
- Reset (RESET_N=0 at a clock edge):
  - Counters = 0; pix_x = pix_y = 0; frame_start = 0; active_sel = 0.
  - RGB = 0; DE = 0; HS = ~HS_POL; VS = ~VS_POL.
  - All delay-pipeline stages are cleared to the same inactive values.
  - Reset mid-frame restarts at (0,0); the first frame_start follows on the first cycle after release.
- Counters:
  - h increments each cycle; at H_TOTAL−1 it wraps to 0 and v increments.
  - v wraps to 0 when h=H_TOTAL−1 and v=V_TOTAL−1.
  - Frame length is exactly H_TOTAL·V_TOTAL cycles.
- Stage-0 timing, combinational on the counters:
  - hs0 active when H_FRONT ≤ h < H_FRONT+H_SYNC; vs0 likewise for v with V_FRONT/V_SYNC.
  - de0 = (h ≥ H_OFF) & (v ≥ V_OFF).
  - pix_x, pix_y and frame_start are registered outputs aligned with the counter outputs (same cycle).
- Alignment:
  - hs0/vs0/de0 pass through a PIPE-deep shift register to VGA_HS/VGA_VS/VGA_DE.
  - The source for counter value t is sampled at t+SRC_LATENCY, then registered once into VGA_RGB.
  - Net: all VGA_* outputs lag the counters by exactly PIPE cycles.
- RGB: VGA_{R,G,B} = selected source when the delayed DE is 1, else forced 0.
- Source select:
  - sel is sampled only on the cycle counters are (0,0).
  - If sel < NUM_SRC, active_sel ← sel; otherwise active_sel is held unchanged.
  - The mux uses active_sel. Because H_OFF ≥ PIPE, the switch lands inside blanking, so there is no mid-frame tear.
  - Changes of sel at any other time are ignored.
- NUM_SRC=1: sel is ignored and active_sel stays 0.

Optional Feature:
- Macro: VGA_TIMING_MUX_SCANLINE_EN.
- Defined: on output lines where the delayed vertical_counter bit 0 is 1, each of R/G/B is shifted right by 1 (halved). Uses the pipelined v, so the effect is aligned with DE.
- Undefined: no dimming; RGB passes unmodified; no extra logic.

Test Plan:
- Default params, hold RESET_N=0 for 5 cycles → VGA_HS=1, VGA_VS=1, DE=0, RGB=0, active_sel=0. After release, frame_start pulses at cycles 0, 112 and 224.
- Timing check, default params:
  - VGA_HS low for 3 cycles starting at h=2+PIPE=4 on each 14-cycle line.
  - VGA_VS low for lines 1–2 (28 cycles).
  - DE high for 8 cycles per line on lines 4–7 only, giving 32 DE cycles per frame.
- src0 = 0x112233, sel=0 → RGB = 0x112233 exactly while DE is high and 0 otherwise. pix_x runs 0..7 and pix_y 0..3 in the visible area.
- Drive sel=2 mid-frame (h=5, v=5) with src2 = 0xAABBCC → the current frame keeps 0x112233. From the next frame's first DE pixel, RGB = 0xAABBCC, and active_sel becomes 2 at (0,0).
- sel=5 with NUM_SRC=3 at a frame boundary → active_sel unchanged, output unchanged. SRC_LATENCY=3 → DE/HS delayed by 4 relative to the counters and RGB still aligned with the source's pixel-counter tag.
- Assert RESET_N=0 for 1 cycle at (h=9, v=6) → next cycle matches the reset values; the restarted frame shows the same counts as the first frame. With VGA_TIMING_MUX_SCANLINE_EN defined, src0 = 0x808080 → lines 5 and 7 output 0x404040, lines 4 and 6 output 0x808080.
